// File: rtl/core_dcache_pkg.sv
// Shared types and byte-lane helpers for the N-way data cache.
// Pure declarations and functions; no state, no latency.
package core_dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB, REFILL, FILL} dcache_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size_e'(size))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] m;
    case (size_e'(size))
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [2:0] off,
                                               input logic [1:0] size);
    logic [63:0] s;
    s = word >> {off, 3'b000};
    case (size_e'(size))
      SZ_B:    return {56'b0, s[7:0]};
      SZ_H:    return {48'b0, s[15:0]};
      SZ_W:    return {32'b0, s[31:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] word, input logic [63:0] data,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [63:0] sh;
    logic [7:0]  be;
    logic [63:0] r;
    sh = data << {off, 3'b000};
    be = byte_mask(off, size);
    r  = word;
    for (int i = 0; i < 8; i++)
      if (be[i]) r[8*i +: 8] = sh[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/core_dcache_plru.sv
// Tree pseudo-LRU for one set: victim select and MRU update of an accessed way.
// Purely combinational; the caller owns the per-set state bits.
module core_dcache_plru #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1,
  parameter int PW       = 1
) (
  input  logic [PW-1:0]    tree,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim,
  output logic [PW-1:0]    tree_next
);
  localparam int LEVELS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  generate
    if (NUM_WAYS == 1) begin : g_single
      assign victim    = '0;
      assign tree_next = tree;
    end else begin : g_tree
      // Each node bit points toward the less recently used subtree.
      always_comb begin
        int node;
        victim = '0;
        node   = 0;
        for (int l = 0; l < LEVELS; l++) begin
          victim[LEVELS-1-l] = tree[node];
          node = 2*node + 1 + int'(tree[node]);
        end
      end

      always_comb begin
        int node;
        tree_next = tree;
        node      = 0;
        for (int l = 0; l < LEVELS; l++) begin
          tree_next[node] = ~access_way[LEVELS-1-l];
          node = 2*node + 1 + int'(access_way[LEVELS-1-l]);
        end
      end
    end
  endgenerate
endmodule

// File: rtl/core_dcache_nway.sv
// N-way write-back/write-allocate dcache; zero-latency hits, one outstanding miss.
// Stalls the core in every non-IDLE state; waits indefinitely for AXI done pulses.
module core_dcache_nway
  import core_dcache_pkg::*;
#(
  parameter int NUM_WAYS        = 2,
  parameter int INDEX_WIDTH     = 7,
  parameter int BLOCK_OFFSET    = 2,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH  = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
  input  logic [CORE_DATA_WIDTH-1:0] i_data_from_core,
  input  logic                       i_read,
  input  logic                       i_write,
  input  logic [1:0]                 i_size,
  output logic                       o_stall,
  output logic [CORE_DATA_WIDTH-1:0] o_data_to_core,
  output logic                       o_load_fault,
  output logic                       o_store_fault,
  output logic                       o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]      o_mem_read_address,
  input  logic                       i_mem_read_done,
  input  logic [AXI_DATA_WIDTH-1:0]  i_block_from_axi,
  output logic                       o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0]      o_mem_write_address,
  output logic [CORE_DATA_WIDTH-1:0] o_mem_write_data,
  output logic [7:0]                 o_mem_write_strobe,
  input  logic                       i_mem_write_done
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET - 3;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << BLOCK_OFFSET;
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int PW        = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  logic [AXI_DATA_WIDTH-1:0]      data_mem [NUM_WAYS][SETS];
  logic [TAG_WIDTH-1:0]           tag_mem  [NUM_WAYS][SETS];
  logic [NUM_WAYS-1:0][SETS-1:0]  valid, dirty;
  logic [SETS-1:0][PW-1:0]        plru;

  dcache_state_e                  state, state_next;
  logic [WAY_W-1:0]               vic_way, vic_sel, hit_way, plru_victim, access_way;
  logic [TAG_WIDTH-1:0]           vic_tag;
  logic [BLOCK_OFFSET-1:0]        beat;
  logic [AXI_DATA_WIDTH-1:0]      fill_buf, hit_line, wb_line, store_line;
  logic [CORE_DATA_WIDTH-1:0]     hit_word, wb_word, store_word;
  logic [PW-1:0]                  plru_next;
  logic [NUM_WAYS-1:0]            way_valid, way_dirty;

  logic [TAG_WIDTH-1:0]           tag;
  logic [INDEX_WIDTH-1:0]         idx;
  logic [BLOCK_OFFSET-1:0]        word_sel;
  logic [2:0]                     byte_off;
  logic                           idle, req, misal, hit, hit_access, miss_start;

  assign tag      = i_addr_from_core[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign idx      = i_addr_from_core[3+BLOCK_OFFSET +: INDEX_WIDTH];
  assign word_sel = i_addr_from_core[3 +: BLOCK_OFFSET];
  assign byte_off = i_addr_from_core[2:0];

  assign idle       = (state == IDLE);
  assign req        = i_read | i_write;
  assign misal      = is_misaligned(byte_off, i_size);
  assign hit_access = idle && req && !misal && hit;
  assign miss_start = idle && req && !misal && !hit;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    way_valid = '0;
    way_dirty = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_valid[w] = valid[w][idx];
      way_dirty[w] = dirty[w][idx];
      if (valid[w][idx] && (tag_mem[w][idx] == tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way wins over the pLRU choice.
  always_comb begin
    vic_sel = plru_victim;
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (!way_valid[w]) vic_sel = WAY_W'(w);
  end

  assign access_way = (state == FILL) ? vic_way : hit_way;

  core_dcache_plru #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W), .PW(PW)) u_plru (
    .tree       (plru[idx]),
    .access_way (access_way),
    .victim     (plru_victim),
    .tree_next  (plru_next)
  );

  always_comb begin
    hit_line = data_mem[hit_way][idx];
    wb_line  = data_mem[vic_way][idx];
    hit_word = '0;
    wb_word  = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (word_sel == BLOCK_OFFSET'(k)) hit_word = hit_line[k*CORE_DATA_WIDTH +: CORE_DATA_WIDTH];
      if (beat == BLOCK_OFFSET'(k))     wb_word  = wb_line[k*CORE_DATA_WIDTH +: CORE_DATA_WIDTH];
    end
    store_word = store_merge(hit_word, i_data_from_core, byte_off, i_size);
    store_line = hit_line;
    for (int k = 0; k < WORDS; k++)
      if (word_sel == BLOCK_OFFSET'(k)) store_line[k*CORE_DATA_WIDTH +: CORE_DATA_WIDTH] = store_word;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (miss_start)
                 state_next = (way_valid[vic_sel] && way_dirty[vic_sel]) ? WB : REFILL;
      WB:      if (i_mem_write_done && beat == '1) state_next = REFILL;
      REFILL:  if (i_mem_read_done) state_next = FILL;
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      valid   <= '0;
      dirty   <= '0;
      plru    <= '0;
      beat    <= '0;
      vic_way <= '0;
    end else begin
      state <= state_next;
      if (miss_start) begin
        vic_way <= vic_sel;
        beat    <= '0;
      end
      if (state == WB && i_mem_write_done) beat <= beat + BLOCK_OFFSET'(1);
      if (hit_access) begin
        plru[idx] <= plru_next;
        if (i_write) dirty[hit_way][idx] <= 1'b1;
      end
      if (state == FILL) begin
        valid[vic_way][idx] <= 1'b1;
        dirty[vic_way][idx] <= 1'b0;
        plru[idx]           <= plru_next;
      end
    end
  end

  // Data/tag storage is never reset; a reset cycle only blocks writes.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (miss_start) vic_tag <= tag_mem[vic_sel][idx];
      if (state == REFILL && i_mem_read_done) fill_buf <= i_block_from_axi;
      if (hit_access && i_write) data_mem[hit_way][idx] <= store_line;
      if (state == FILL) begin
        data_mem[vic_way][idx] <= fill_buf;
        tag_mem[vic_way][idx]  <= tag;
      end
    end
  end

  assign o_stall            = !i_rst && (!idle || miss_start);
  assign o_load_fault       = !i_rst && idle && i_read && !i_write && misal;
  assign o_store_fault      = !i_rst && idle && i_write && misal;
  assign o_data_to_core     = (!i_rst && hit_access) ? load_extract(hit_word, byte_off, i_size) : '0;
  assign o_mem_read_req     = !i_rst && (state == REFILL);
  assign o_mem_read_address = o_mem_read_req ? {tag, idx, {(BLOCK_OFFSET+3){1'b0}}} : '0;
  assign o_mem_write_valid  = !i_rst && (state == WB);
  assign o_mem_write_address = o_mem_write_valid ? {vic_tag, idx, beat, 3'b000} : '0;
  assign o_mem_write_data   = o_mem_write_valid ? wb_word : '0;
  assign o_mem_write_strobe = 8'hFF;
endmodule

// File: tb/tb_core_dcache_nway.sv
// Directed bench for core_dcache_nway (2 ways, 4-word blocks): table-driven hits plus miss sequences.
module tb_core_dcache_nway;
  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [63:0]  i_addr_from_core, i_data_from_core;
  logic         i_read, i_write;
  logic [1:0]   i_size;
  logic         o_stall, o_load_fault, o_store_fault;
  logic [63:0]  o_data_to_core;
  logic         o_mem_read_req, i_mem_read_done;
  logic [63:0]  o_mem_read_address;
  logic [255:0] i_block_from_axi;
  logic         o_mem_write_valid, i_mem_write_done;
  logic [63:0]  o_mem_write_address, o_mem_write_data;
  logic [7:0]   o_mem_write_strobe;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  core_dcache_nway dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_addr_from_core(i_addr_from_core), .i_data_from_core(i_data_from_core),
    .i_read(i_read), .i_write(i_write), .i_size(i_size),
    .o_stall(o_stall), .o_data_to_core(o_data_to_core),
    .o_load_fault(o_load_fault), .o_store_fault(o_store_fault),
    .o_mem_read_req(o_mem_read_req), .o_mem_read_address(o_mem_read_address),
    .i_mem_read_done(i_mem_read_done), .i_block_from_axi(i_block_from_axi),
    .o_mem_write_valid(o_mem_write_valid), .o_mem_write_address(o_mem_write_address),
    .o_mem_write_data(o_mem_write_data), .o_mem_write_strobe(o_mem_write_strobe),
    .i_mem_write_done(i_mem_write_done)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        stall;
    logic        lf;
    logic        sf;
    logic        cd;
    logic [63:0] rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  localparam logic [63:0] W10 = 64'h1122334455667788;
  localparam logic [63:0] W11 = 64'hA0A1A2A3A4A5A6A7;
  localparam logic [63:0] W12 = 64'hB0B1B2B3B4B5B6B7;
  localparam logic [63:0] W13 = 64'hC0C1C2C3C4C5C6C7;
  localparam logic [63:0] L1000_W0 = 64'hDEADBEEFAB665555;
  logic [255:0] blk1, blk2, blk3;
  logic [63:0]  wb_exp [4];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                              input logic [1:0] sz, input logic st, input logic lf, input logic sf,
                              input logic cd, input logic [63:0] rdat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.size = sz;
    v.stall = st; v.lf = lf; v.sf = sf; v.cd = cd; v.rdata = rdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                       input logic [1:0] sz);
    i_read = rd; i_write = wr; i_addr_from_core = a; i_data_from_core = d; i_size = sz;
  endtask

  task automatic idle_bus();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 2'd0);
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  // Waits for the refill request, answers after lat cycles, and ends at the
  // negedge of the replay-hit cycle (two cycles after the done pulse).
  task automatic refill(input string nm, input logic [63:0] exp_addr, input logic [255:0] blk, input int lat);
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_mem_read_req && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk({nm, " read_req"}, o_mem_read_req, 1'b1);
    chk({nm, " read_addr"}, o_mem_read_address, exp_addr);
    chk({nm, " no wb during refill"}, o_mem_write_valid, 1'b0);
    repeat (lat) @(negedge i_clk);
    chk({nm, " read_req held"}, o_mem_read_req, 1'b1);
    step();
    i_mem_read_done = 1'b1;
    i_block_from_axi = blk;
    step();
    i_mem_read_done = 1'b0;
    @(negedge i_clk);
    chk({nm, " fill stall"}, o_stall, 1'b1);
    chk({nm, " fill req low"}, o_mem_read_req, 1'b0);
    step();
    @(negedge i_clk);
    chk({nm, " replay stall"}, o_stall, 1'b0);
  endtask

  task automatic probe(input string nm, input logic [63:0] a, input logic exp_stall, input logic [63:0] exp_data);
    drive(1'b1, 1'b0, a, 64'h0, 2'd3);
    @(negedge i_clk);
    chk({nm, " stall"}, o_stall, exp_stall);
    if (!exp_stall) chk({nm, " data"}, o_data_to_core, exp_data);
    #1;
    if (exp_stall) idle_bus();
    step();
    idle_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    blk1 = {W13, W12, W11, W10};
    blk2 = {64'h0000000020000018, 64'h0000000020000010, 64'h0000000020000008, 64'h0000000020000000};
    blk3 = {64'h0000000030000018, 64'h0000000030000010, 64'h0000000030000008, 64'h0000000030000000};
    wb_exp[0] = L1000_W0; wb_exp[1] = W11; wb_exp[2] = W12; wb_exp[3] = W13;

    vt[0]  = mk(1'b1, 1'b0, 64'h1000, 64'h0,        2'd3, 1'b0, 1'b0, 1'b0, 1'b1, W10);
    vt[1]  = mk(1'b1, 1'b0, 64'h1008, 64'h0,        2'd3, 1'b0, 1'b0, 1'b0, 1'b1, W11);
    vt[2]  = mk(1'b0, 1'b1, 64'h1003, 64'hAB,       2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    vt[3]  = mk(1'b1, 1'b0, 64'h1000, 64'h0,        2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11223344AB667788);
    vt[4]  = mk(1'b1, 1'b0, 64'h1003, 64'h0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hAB);
    vt[5]  = mk(1'b1, 1'b0, 64'h1001, 64'h0,        2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    vt[6]  = mk(1'b0, 1'b1, 64'h1004, 64'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    vt[7]  = mk(1'b1, 1'b0, 64'h1000, 64'h0,        2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 64'hDEADBEEFAB667788);
    vt[8]  = mk(1'b1, 1'b0, 64'h1006, 64'h0,        2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD);
    vt[9]  = mk(1'b1, 1'b1, 64'h1000, 64'h5555,     2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h7788);
    vt[10] = mk(1'b1, 1'b0, 64'h1000, 64'h0,        2'd3, 1'b0, 1'b0, 1'b0, 1'b1, L1000_W0);
    vt[11] = mk(1'b0, 1'b1, 64'h1004, 64'h12345678, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    vt[12] = mk(1'b1, 1'b0, 64'h1000, 64'h0,        2'd3, 1'b0, 1'b0, 1'b0, 1'b1, L1000_W0);
    vt[13] = mk(1'b1, 1'b0, 64'h1002, 64'h0,        2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    vt[14] = mk(1'b1, 1'b0, 64'h1018, 64'h0,        2'd3, 1'b0, 1'b0, 1'b0, 1'b1, W13);

    idle_bus();
    i_rst = 1'b1;
    i_mem_read_done = 1'b0;
    i_mem_write_done = 1'b0;
    i_block_from_axi = '0;
    repeat (3) step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset stall", o_stall, 1'b0);
    chk("reset read_req", o_mem_read_req, 1'b0);
    chk("reset write_valid", o_mem_write_valid, 1'b0);
    chk("reset data", o_data_to_core, 64'h0);
    chk("reset faults", {o_load_fault, o_store_fault}, 2'b00);
    step();

    // Cold load
    drive(1'b1, 1'b0, 64'h1000, 64'h0, 2'd3);
    @(negedge i_clk);
    chk("cold stall", o_stall, 1'b1);
    chk("cold req not yet", o_mem_read_req, 1'b0);
    refill("cold", 64'h1000, blk1, 3);
    chk("cold data", o_data_to_core, W10);
    step();
    idle_bus();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].size);
      @(negedge i_clk);
      chk($sformatf("vec%0d stall", i), o_stall, vt[i].stall);
      chk($sformatf("vec%0d load_fault", i), o_load_fault, vt[i].lf);
      chk($sformatf("vec%0d store_fault", i), o_store_fault, vt[i].sf);
      chk($sformatf("vec%0d read_req", i), o_mem_read_req, 1'b0);
      if (vt[i].cd) chk($sformatf("vec%0d data", i), o_data_to_core, vt[i].rdata);
      step();
    end
    idle_bus();

    // Stray done pulses in IDLE must not disturb the FSM
    i_mem_read_done = 1'b1;
    i_mem_write_done = 1'b1;
    step();
    i_mem_read_done = 1'b0;
    i_mem_write_done = 1'b0;
    probe("stray done hit", 64'h1000, 1'b0, L1000_W0);

    // Second line in the same set goes to the invalid way
    drive(1'b1, 1'b0, 64'h2000, 64'h0, 2'd3);
    @(negedge i_clk);
    chk("fill2000 stall", o_stall, 1'b1);
    refill("fill2000", 64'h2000, blk2, 1);
    chk("fill2000 data", o_data_to_core, blk2[63:0]);
    step();
    idle_bus();

    probe("touch1000", 64'h1000, 1'b0, L1000_W0);

    // pLRU victim is the 0x2000 way, which is clean
    drive(1'b1, 1'b0, 64'h3000, 64'h0, 2'd3);
    @(negedge i_clk);
    chk("fill3000 stall", o_stall, 1'b1);
    refill("fill3000", 64'h3000, blk3, 2);
    chk("fill3000 data", o_data_to_core, blk3[63:0]);
    step();
    idle_bus();

    probe("evicted2000", 64'h2000, 1'b1, 64'h0);
    probe("kept1000", 64'h1000, 1'b0, L1000_W0);

    drive(1'b0, 1'b1, 64'h3008, 64'h5A5A5A5A5A5A5A5A, 2'd3);
    @(negedge i_clk);
    chk("store3008 stall", o_stall, 1'b0);
    step();
    idle_bus();

    // Dirty victim 0x1000: four write-back beats with growing done gaps
    drive(1'b1, 1'b0, 64'h2000, 64'h0, 2'd3);
    @(negedge i_clk);
    chk("dirty miss stall", o_stall, 1'b1);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      @(negedge i_clk);
      while (!o_mem_write_valid && n < 20) begin
        @(negedge i_clk);
        n++;
      end
      chk($sformatf("wb%0d valid", k), o_mem_write_valid, 1'b1);
      chk($sformatf("wb%0d wait", k), 64'(n), 64'h0);
      chk($sformatf("wb%0d addr", k), o_mem_write_address, 64'h1000 + 64'(8*k));
      chk($sformatf("wb%0d data", k), o_mem_write_data, wb_exp[k]);
      chk($sformatf("wb%0d strobe", k), o_mem_write_strobe, 8'hFF);
      chk($sformatf("wb%0d no read_req", k), o_mem_read_req, 1'b0);
      repeat (k) @(negedge i_clk);
      chk($sformatf("wb%0d held", k), o_mem_write_valid, 1'b1);
      step();
      i_mem_write_done = 1'b1;
      step();
      i_mem_write_done = 1'b0;
    end
    refill("after wb", 64'h2000, blk2, 0);
    chk("after wb data", o_data_to_core, blk2[63:0]);
    step();
    idle_bus();

    // Reset in the middle of a refill
    drive(1'b1, 1'b0, 64'h1020, 64'h0, 2'd3);
    @(negedge i_clk);
    chk("rst miss stall", o_stall, 1'b1);
    begin
      int n;
      n = 0;
      @(negedge i_clk);
      while (!o_mem_read_req && n < 50) begin
        @(negedge i_clk);
        n++;
      end
    end
    chk("rst pre req", o_mem_read_req, 1'b1);
    chk("rst pre addr", o_mem_read_address, 64'h1020);
    #1 i_rst = 1'b1;
    #1;
    chk("rst drops req", o_mem_read_req, 1'b0);
    chk("rst drops wb", o_mem_write_valid, 1'b0);
    step();
    idle_bus();
    step();
    i_rst = 1'b0;

    drive(1'b1, 1'b0, 64'h2000, 64'h0, 2'd3);
    @(negedge i_clk);
    chk("post-rst miss", o_stall, 1'b1);
    chk("post-rst no wb", o_mem_write_valid, 1'b0);
    refill("post-rst", 64'h2000, blk2, 1);
    chk("post-rst data", o_data_to_core, blk2[63:0]);
    step();
    idle_bus();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
